// File: rtl/pipe_pkg.sv
// Shared pipeline constants: status codes, icodes, register IDs and the
// hazard controller state type, reused by every pipeline stage.
package pipe_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

  function automatic logic is_exc(input logic [2:0] stat);
    return stat != SAOK;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Holds at all-ones instead of wrapping so long runs never read as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, ret and mispredict handling, memory
// wait stalls with timeout, exception halt and saturating perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int PRED_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             mem_busy,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
);

  localparam int              WC_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST    = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
  localparam logic            PRED_TAKEN = (PRED_MODE == 0);

  hz_state_t       state, next_state;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use, ret_pend, mispred, w_exc, m_exc;
  logic            timeout_hit, mem_hold;

  assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_pend = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mispred  = (E_icode == IJXX) && (e_cnd != PRED_TAKEN);
  assign w_exc    = is_exc(W_stat);
  assign m_exc    = is_exc(m_stat);

  assign timeout_hit = (state == WAIT_MEM) && mem_busy && (wait_cnt == WC_LAST);
  // Once mem_busy drops the load data is ready, so that cycle uses RUN controls.
  assign mem_hold    = ((state == RUN) && mem_busy && !w_exc) ||
                       ((state == WAIT_MEM) && mem_busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halt_stat <= SAOK;
    end else begin
      state <= next_state;
      if (state == WAIT_MEM)
        wait_cnt <= wait_cnt + WC_ONE;
      else
        wait_cnt <= '0;
      if ((state == RUN) && w_exc)
        halt_stat <= W_stat;
      else if (timeout_hit)
        halt_stat <= SADR;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (w_exc)
          next_state = HALTED;
        else if (mem_busy)
          next_state = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (timeout_hit)
          next_state = HALTED;
        else if (!mem_busy)
          next_state = RUN;
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    if (!rst) begin
      if (state == HALTED) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_stall = 1'b1;
        W_stall = 1'b1;
      end else if (mem_hold) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_stall  = 1'b1;
        W_bubble = 1'b1;
      end else begin
        F_stall  = load_use | ret_pend;
        D_stall  = load_use;
        D_bubble = mispred | (ret_pend & ~load_use);
        E_bubble = mispred | load_use;
        M_bubble = m_exc | w_exc;
        W_stall  = w_exc;
      end
    end
  end

  assign halted      = (state == HALTED);
  assign mem_timeout = timeout_hit;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (F_stall && (state != HALTED)),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (D_bubble | E_bubble | M_bubble | W_bubble),
    .count (bubble_cycles)
  );

endmodule
